// File: rtl/vliw_pkg.sv
// Shared types and constants for the two-slot VLIW core front end.
package vliw_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned SLOT_W  = 16;
  localparam int unsigned CNT_W   = 3;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0030;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXC  = 2'd2
  } state_t;

  // What the IF/ID register does on the coming edge.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_FETCH  = 2'd1,
    ACT_SQUASH = 2'd2,
    ACT_EXC    = 2'd3
  } act_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority select of next PC, next state and IF/ID action.
module pc_next_sel
  import vliw_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter int unsigned EXC_BUBBLES = 3
) (
  input  state_t             state_q,
  input  logic [CNT_W-1:0]   cnt_q,
  input  logic [31:0]        pc_q,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               exc_valid,
  output state_t             state_d,
  output logic [31:0]        pc_d,
  output logic [CNT_W-1:0]   cnt_d,
  output act_t               act,
  output logic               misalign_set
);

  localparam logic [CNT_W-1:0] EXC_CNT = CNT_W'(EXC_BUBBLES - 1);

  logic redirect_bad;

  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    act          = ACT_HOLD;
    misalign_set = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // A misaligned branch target is reported as an exception.
        if (exc_valid || redirect_bad) begin
          misalign_set = !exc_valid && redirect_bad;
          pc_d         = EXC_VECTOR;
          cnt_d        = EXC_CNT;
          state_d      = ST_EXC;
          act          = ACT_EXC;
        end else if (redirect_valid) begin
          pc_d = redirect_pc;
          act  = ACT_SQUASH;
        end else if (!stall) begin
          pc_d = pc_q + 32'd4;
          act  = ACT_FETCH;
        end
      end
      ST_EXC: begin
        pc_d = EXC_VECTOR;
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_BOOT;
    endcase
  end

endmodule

// File: rtl/vliw_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address
// and captures the returned bundle into the IF/ID register.
module vliw_fetch_stage
  import vliw_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter int unsigned EXC_BUBBLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               exc_valid,
  output logic [31:0]        imem_pc,
  input  logic [INSTR_W-1:0] imem_ir,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_ir,
  output logic [31:0]        ifid_pc,
  output logic [31:0]        ifid_pc4,
  output logic [31:0]        epc,
  output logic               misalign,
  output state_t             dbg_state
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        pc_q, pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_ir_q, ifid_ir_d;
  logic [31:0]        ifid_pc_q, ifid_pc_d;
  logic [31:0]        ifid_pc4_q, ifid_pc4_d;
  logic [31:0]        epc_q, epc_d;
  logic               misalign_q, misalign_d;
  logic               misalign_set;
  act_t               act;

  pc_next_sel #(
    .EXC_VECTOR  (EXC_VECTOR),
    .EXC_BUBBLES (EXC_BUBBLES)
  ) u_pc_next_sel (
    .state_q        (state_q),
    .cnt_q          (cnt_q),
    .pc_q           (pc_q),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .state_d        (state_d),
    .pc_d           (pc_d),
    .cnt_d          (cnt_d),
    .act            (act),
    .misalign_set   (misalign_set)
  );

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_ir_d    = ifid_ir_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    epc_d        = epc_q;
    misalign_d   = misalign_q | misalign_set;
    case (act)
      ACT_FETCH: begin
        ifid_valid_d = 1'b1;
        ifid_ir_d    = imem_ir;
        ifid_pc_d    = pc_q;
        ifid_pc4_d   = pc_q + 32'd4;
      end
      ACT_SQUASH: ifid_valid_d = 1'b0;
      ACT_EXC: begin
        ifid_valid_d = 1'b0;
        epc_d        = ifid_pc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_BOOT;
      cnt_q        <= '0;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_ir_q    <= '0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      epc_q        <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_ir_q    <= ifid_ir_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      epc_q        <= epc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_pc    = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_ir    = ifid_ir_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign epc        = epc_q;
  assign misalign   = misalign_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vliw_fetch_stage.sv
// Directed bench for vliw_fetch_stage: boot, sequential fetch, stall,
// redirect with index wrap, exception window, misalign and async reset.
module tb_vliw_fetch_stage;
  import vliw_pkg::*;

  logic         clk;
  logic         reset;
  logic         stall;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         exc_valid;
  logic [31:0]  imem_pc;
  logic [31:0]  imem_ir;
  logic         ifid_valid;
  logic [31:0]  ifid_ir;
  logic [31:0]  ifid_pc;
  logic [31:0]  ifid_pc4;
  logic [31:0]  epc;
  logic         misalign;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;

  vliw_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .imem_pc        (imem_pc),
    .imem_ir        (imem_ir),
    .ifid_valid     (ifid_valid),
    .ifid_ir        (ifid_ir),
    .ifid_pc        (ifid_pc),
    .ifid_pc4       (ifid_pc4),
    .epc            (epc),
    .misalign       (misalign),
    .dbg_state      (dbg_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_ir(input int w);
    return 32'hC0DE_0000 + 32'(w);
  endfunction

  assign imem_ir = word_ir(int'(imem_pc[5:2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; exc_valid = 1'b0;
    step(); step();
    checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL rst_imem_pc got %h exp %h", imem_pc, 32'h0); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifid_valid); end
    checks++; if ({ifid_ir, ifid_pc, ifid_pc4, epc} !== 128'h0) begin errors++; $display("FAIL rst_regs got %h %h %h %h exp 0", ifid_ir, ifid_pc, ifid_pc4, epc); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b exp 0", misalign); end
    checks++; if (dbg_state !== ST_BOOT) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, ST_BOOT); end
    reset = 1'b1;
  endtask

  task automatic test_boot_and_fetch();
    step();
    checks++; if (ifid_valid !== 1'b0 || dbg_state !== ST_RUN || imem_pc !== 32'h0) begin errors++; $display("FAIL boot_edge1 got v=%b st=%0d pc=%h exp v=0 st=1 pc=0", ifid_valid, dbg_state, imem_pc); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 32'(4*i) || ifid_pc4 !== 32'(4*i+4) || ifid_ir !== word_ir(i) || imem_pc !== 32'(4*i+4)) begin
        errors++;
        $display("FAIL seq_fetch%0d got v=%b pc=%h pc4=%h ir=%h imem=%h exp pc=%h", i, ifid_valid, ifid_pc, ifid_pc4, ifid_ir, imem_pc, 32'(4*i));
      end
      if (i == 1) begin
        // stall while the PC points at 8
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
          step();
          checks++;
          if (imem_pc !== 32'd8 || ifid_pc !== 32'd4 || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall%0d got imem=%h pc=%h v=%b exp imem=8 pc=4 v=1", k, imem_pc, ifid_pc, ifid_valid);
          end
        end
        stall = 1'b0;
      end
    end
  endtask

  task automatic test_redirect();
    // IF/ID now holds 12, PC is 16; walk until PC reaches 44
    for (int a = 16; a < 44; a += 4) step();
    checks++; if (imem_pc !== 32'd44 || ifid_pc !== 32'd40) begin errors++; $display("FAIL pre_redirect got imem=%h pc=%h exp 2c 28", imem_pc, ifid_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'd60; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || imem_pc !== 32'd60) begin errors++; $display("FAIL redirect_squash got v=%b imem=%h exp v=0 imem=3c", ifid_valid, imem_pc); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'd60 || ifid_ir !== word_ir(15) || ifid_pc4 !== 32'd64) begin errors++; $display("FAIL redirect_target got v=%b pc=%h ir=%h pc4=%h exp pc=3c", ifid_valid, ifid_pc, ifid_ir, ifid_pc4); end
    step();
    checks++; if (ifid_pc !== 32'd64 || ifid_ir !== word_ir(0) || imem_pc !== 32'd68) begin errors++; $display("FAIL wrap64 got pc=%h ir=%h imem=%h exp pc=40 ir=%h", ifid_pc, ifid_ir, imem_pc, word_ir(0)); end
  endtask

  task automatic test_exception();
    redirect_valid = 1'b1; redirect_pc = 32'd52;
    step();
    redirect_valid = 1'b0;
    step();
    checks++; if (ifid_pc !== 32'd52 || ifid_valid !== 1'b1) begin errors++; $display("FAIL pre_exc got pc=%h v=%b exp 34 1", ifid_pc, ifid_valid); end
    exc_valid = 1'b1;
    step();
    checks++; if (epc !== 32'd52 || imem_pc !== 32'h30 || dbg_state !== ST_EXC) begin errors++; $display("FAIL exc_accept got epc=%h imem=%h st=%0d exp 34 30 2", epc, imem_pc, dbg_state); end
    // redirect and a nested exception during the window are ignored
    redirect_valid = 1'b1; redirect_pc = 32'd8;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (ifid_valid !== 1'b0 || imem_pc !== 32'h30) begin
        errors++;
        $display("FAIL exc_bubble%0d got v=%b imem=%h exp v=0 imem=30", b, ifid_valid, imem_pc);
      end
      if (b < 3) step();
      redirect_valid = 1'b0; exc_valid = 1'b0;
    end
    checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL exc_exit got st=%0d exp 1", dbg_state); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h30 || ifid_ir !== word_ir(12) || epc !== 32'd52) begin errors++; $display("FAIL exc_resume got v=%b pc=%h ir=%h epc=%h exp pc=30", ifid_valid, ifid_pc, ifid_ir, epc); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    step();
    redirect_valid = 1'b0;
    checks++; if (misalign !== 1'b1 || epc !== 32'h30 || imem_pc !== 32'h30 || ifid_valid !== 1'b0 || dbg_state !== ST_EXC) begin errors++; $display("FAIL misalign_exc got m=%b epc=%h imem=%h v=%b st=%0d exp 1 30 30 0 2", misalign, epc, imem_pc, ifid_valid, dbg_state); end
    step(); step(); step(); step();
    checks++; if (misalign !== 1'b1 || ifid_valid !== 1'b1 || ifid_pc !== 32'h30) begin errors++; $display("FAIL misalign_sticky got m=%b v=%b pc=%h exp 1 1 30", misalign, ifid_valid, ifid_pc); end
    exc_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd4;
    step();
    exc_valid = 1'b0; redirect_valid = 1'b0;
    checks++; if (imem_pc !== 32'h30 || dbg_state !== ST_EXC || epc !== 32'h30) begin errors++; $display("FAIL exc_wins got imem=%h st=%0d epc=%h exp 30 2 30", imem_pc, dbg_state, epc); end
  endtask

  task automatic test_reset_mid_exc();
    step();
    reset = 1'b0;
    #1;
    checks++; if (imem_pc !== 32'h0 || ifid_valid !== 1'b0 || {ifid_ir, ifid_pc, ifid_pc4, epc} !== 128'h0 || misalign !== 1'b0 || dbg_state !== ST_BOOT) begin errors++; $display("FAIL reset_mid_exc got imem=%h v=%b epc=%h m=%b st=%0d exp all reset", imem_pc, ifid_valid, epc, misalign, dbg_state); end
    step();
    reset = 1'b1;
    step();
    checks++; if (ifid_valid !== 1'b0 || dbg_state !== ST_RUN) begin errors++; $display("FAIL reboot_edge1 got v=%b st=%0d exp 0 1", ifid_valid, dbg_state); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_ir !== word_ir(0)) begin errors++; $display("FAIL reboot_fetch got v=%b pc=%h ir=%h exp 1 0 %h", ifid_valid, ifid_pc, ifid_ir, word_ir(0)); end
  endtask

  initial begin
    test_reset();
    test_boot_and_fetch();
    test_redirect();
    test_exception();
    test_misalign();
    test_reset_mid_exc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
